acc_seq_ctrl: RTL and testbench

Parametrised start/done accumulate controller, the successor to the fixed 32-bit simple accumulate controller. On start it runs a programmable-length job in one of four modes:
- sum of an input stream
- sum of squares of an input stream
- internal index sum 1..N
- running unsigned maximum

It has a valid/ready input handshake, a busy flag, and a sticky overflow flag. It sits under top-level sequencing logic, which pulses or holds start and collects the result on done.

---
 rtl/acc_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : acc_seq_ctrl
// Brief    : Start/done accumulate controller. One job per start. Each job
//            runs for a programmable length in one of four modes: stream sum,
//            stream sum of squares, internal index sum 1..N, or running
//            unsigned maximum. The block has a valid/ready input handshake, a
//            busy flag and a sticky overflow flag.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module acc_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic              ovf_o
);

    // Job modes as captured at start acceptance
    localparam logic [1:0] MODE_SUM = 2'd0;
    localparam logic [1:0] MODE_SQR = 2'd1;
    localparam logic [1:0] MODE_IDX = 2'd2;
    localparam logic [1:0] MODE_MAX = 2'd3;

    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic               ovf_q,   ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   len_q,   len_d;
    logic [1:0]         mode_q,  mode_d;

    logic [PROD_W-1:0]  w_prod;
    logic [CNT_W-1:0]   w_count_inc;
    logic [ACC_W-1:0]   w_data_ext;
    logic [ACC_W-1:0]   w_sq_ext;
    logic [ACC_W-1:0]   w_idx_ext;
    logic [ACC_W-1:0]   w_addend;
    logic [ACC_W:0]     w_sum;
    logic               w_step;

    // The index step in mode 2 is count+1, which is also the next count value.
    assign w_count_inc = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_prod      = data_i * data_i;

    // Fit the operands to the accumulator width. Zero-extend narrower
    // operands. Keep only the low bits of wider operands, so wrapping
    // happens in the product before it is added.
    generate
        if (DATA_W >= ACC_W) begin : g_data_trunc
            assign w_data_ext = data_i[ACC_W-1:0];
        end else begin : g_data_zext
            assign w_data_ext = {{(ACC_W-DATA_W){1'b0}}, data_i};
        end

        if (PROD_W >= ACC_W) begin : g_sq_trunc
            assign w_sq_ext = w_prod[ACC_W-1:0];
        end else begin : g_sq_zext
            assign w_sq_ext = {{(ACC_W-PROD_W){1'b0}}, w_prod};
        end

        if (CNT_W >= ACC_W) begin : g_idx_trunc
            assign w_idx_ext = w_count_inc[ACC_W-1:0];
        end else begin : g_idx_zext
            assign w_idx_ext = {{(ACC_W-CNT_W){1'b0}}, w_count_inc};
        end
    endgenerate

    // Select the addend for the additive modes (the max mode uses w_data_ext)
    always_comb begin
        w_addend = w_data_ext;
        case (mode_q)
            MODE_SUM: w_addend = w_data_ext;
            MODE_SQR: w_addend = w_sq_ext;
            MODE_IDX: w_addend = w_idx_ext;
            default:  w_addend = w_data_ext;
        endcase
    end

    // One extra bit holds the carry out of the accumulator, which sets the overflow flag
    assign w_sum = {1'b0, acc_q} + {1'b0, w_addend};

    // A step happens on every RUN cycle in index mode. In stream modes it needs a valid beat.
    assign w_step = (state_q == ST_RUN) && ((mode_q == MODE_IDX) || valid_i);

    // Next-state logic, datapath updates and output decode of the controller
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        len_d   = len_q;
        mode_d  = mode_q;
        ready_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    mode_d  = mode_i;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    state_d = (len_i == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                busy_o  = 1'b1;
                ready_o = (mode_q != MODE_IDX);
                if (w_step) begin
                    count_d = w_count_inc;
                    if (mode_q == MODE_MAX) begin
                        if (w_data_ext > acc_q) begin
                            acc_d = w_data_ext;
                        end
                    end else begin
                        acc_d = w_sum[ACC_W-1:0];
                        ovf_d = ovf_q | w_sum[ACC_W];
                    end
                    if (w_count_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset is asynchronous and clears everything
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
            mode_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_seq_ctrl
// Brief    : Self-checking bench for acc_seq_ctrl. It covers fixed job
//            vectors, hand-written multi-cycle sequences, and randomized
//            jobs checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_seq_ctrl;

    logic        clk_i;
    logic        rstn_i;
    logic        start_i;
    logic [7:0]  len_i;
    logic [1:0]  mode_i;
    logic [15:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] acc_o;
    logic        ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] stim [256];

    typedef struct packed {
        logic [1:0]       mode;
        logic [7:0]       len;
        logic [4:0][15:0] d;
        logic [31:0]      exp_acc;
        logic             exp_ovf;
    } vec_t;

    vec_t vq[$];

    acc_seq_ctrl dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (start_i),
        .len_i   (len_i),
        .mode_i  (mode_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .acc_o   (acc_o),
        .ovf_o   (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] m, input int n,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] d, input logic [15:0] e,
                           input logic [31:0] ea, input logic eo);
        vec_t v;
        v.mode    = m;
        v.len     = 8'(n);
        v.d[0]    = a;
        v.d[1]    = b;
        v.d[2]    = c;
        v.d[3]    = d;
        v.d[4]    = e;
        v.exp_acc = ea;
        v.exp_ovf = eo;
        vq.push_back(v);
    endtask

    // Reference model: applies each mode's rule to stim[] with 64-bit arithmetic
    function automatic void model(input logic [1:0] m, input int n,
                                  output logic [31:0] ea, output logic eo);
        longint unsigned a;
        longint unsigned term;
        a  = 0;
        eo = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'd0:    term = 64'(stim[i]);
                2'd1:    term = 64'(stim[i]) * 64'(stim[i]);
                2'd2:    term = 64'(i + 1);
                default: term = 0;
            endcase
            if (m == 2'd3) begin
                if (64'(stim[i]) > a) a = 64'(stim[i]);
            end else begin
                a = a + term;
                if (a >= 64'h1_0000_0000) begin
                    eo = 1'b1;
                    a  = a - 64'h1_0000_0000;
                end
            end
        end
        ea = a[31:0];
    endfunction

    // Starts a job from IDLE (called at posedge+1). It feeds stim[] with optional
    // stalls and checks the handshake, latency and result, plus the one-cycle done pulse.
    task automatic run_job(input string tag, input logic [1:0] m, input int n,
                           input int gap_at, input int gap_n, input bit rnd,
                           input logic [31:0] eacc, input logic eovf);
        int   beat = 0;
        int   cyc = 0;
        int   stalls = 0;
        int   gaps = 0;
        bit   busy_bad = 0;
        bit   rdy_bad = 0;
        logic rdy;
        start_i = 1'b1;
        len_i   = 8'(n);
        mode_i  = m;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        len_i   = 8'($urandom);
        mode_i  = 2'($urandom);
        while (!done_o && cyc < 1000) begin
            if (busy_o !== 1'b1) busy_bad = 1;
            if (ready_o !== (m != 2'd2)) rdy_bad = 1;
            rdy     = ready_o;
            valid_i = 1'b0;
            data_i  = 16'($urandom);
            if (m == 2'd2) begin
                valid_i = 1'($urandom);
            end else if (beat < n) begin
                if (beat == gap_at && gaps < gap_n) begin
                    gaps++;
                    stalls++;
                end else if (rnd && $urandom_range(0, 3) == 0) begin
                    stalls++;
                end else begin
                    valid_i = 1'b1;
                    data_i  = stim[beat];
                end
            end
            @(posedge clk_i); #1;
            if (m != 2'd2 && valid_i && rdy) beat++;
            cyc++;
        end
        valid_i = 1'b0;
        chk({tag, " done"},    32'(done_o), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(n + stalls));
        chk({tag, " beats"},   32'(beat), (m == 2'd2) ? 32'd0 : 32'(n));
        chk({tag, " busy"},    32'(busy_bad), 32'd0);
        chk({tag, " ready"},   32'(rdy_bad), 32'd0);
        chk({tag, " acc"},     acc_o, eacc);
        chk({tag, " ovf"},     32'(ovf_o), 32'(eovf));
        chk({tag, " done busy"}, 32'({busy_o, ready_o}), 32'd0);
        @(posedge clk_i); #1;
        chk({tag, " pulse"},    32'(done_o), 32'd0);
        chk({tag, " idle acc"}, acc_o, eacc);
    endtask

    initial begin
        int          nb;
        int          cyc;
        bit          done_seen;
        logic [31:0] ea;
        logic        eo;
        logic [1:0]  m;
        int          n;

        rstn_i  = 1'b0;
        start_i = 1'b0;
        len_i   = 8'd0;
        mode_i  = 2'd0;
        data_i  = 16'd0;
        valid_i = 1'b0;
        for (int i = 0; i < 256; i++) stim[i] = 16'd0;

        #3;
        chk("reset acc",  acc_o, 32'd0);
        chk("reset ctrl", 32'({ovf_o, done_o, busy_o, ready_o}), 32'd0);
        repeat (2) @(posedge clk_i);
        #3 rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // Start held high: mode 2 len 10, then auto-restart, then reset mid-run
        start_i = 1'b1;
        mode_i  = 2'd2;
        len_i   = 8'd10;
        @(posedge clk_i); #1;
        nb  = 0;
        cyc = 0;
        while (!done_o && cyc < 50) begin
            if (busy_o) nb++;
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("held busy cycles", 32'(nb), 32'd10);
        chk("held done",        32'(done_o), 32'd1);
        chk("held acc",         acc_o, 32'd55);
        chk("held ovf",         32'(ovf_o), 32'd0);
        @(posedge clk_i); #1;
        chk("held idle", 32'({done_o, busy_o}), 32'd0);
        chk("held idle acc", acc_o, 32'd55);
        @(posedge clk_i); #1;
        chk("auto restart busy", 32'(busy_o), 32'd1);
        chk("auto restart acc",  acc_o, 32'd0);
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("mid job partial acc", acc_o, 32'd6);
        #2 rstn_i = 1'b0;
        #1;
        chk("async reset acc", acc_o, 32'd0);
        chk("async reset ctrl", 32'({ovf_o, done_o, busy_o, ready_o}), 32'd0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (done_o) done_seen = 1;
        end
        #2 rstn_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) done_seen = 1;
        end
        chk("no done after reset", 32'(done_seen), 32'd0);
        run_job("post reset idx", 2'd2, 10, -1, 0, 0, 32'd55, 1'b0);

        // Stall: two idle cycles between the 2nd and 3rd beats
        stim[0] = 16'd3; stim[1] = 16'd5; stim[2] = 16'd7; stim[3] = 16'd9;
        run_job("stall sum", 2'd0, 4, 2, 2, 0, 32'd24, 1'b0);

        // Table of fixed jobs, applied back to back without stalls
        add_vec(2'd1, 4, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 32'd30, 1'b0);
        add_vec(2'd3, 5, 16'd7, 16'h20, 16'd3, 16'h1F, 16'd0, 32'h20, 1'b0);
        add_vec(2'd1, 2, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 32'hFFFC0002, 1'b1);
        add_vec(2'd0, 1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 32'd1, 1'b0);
        add_vec(2'd0, 0, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 32'd0, 1'b0);
        add_vec(2'd2, 255, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd32640, 1'b0);
        add_vec(2'd0, 4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 32'h3FFFC, 1'b0);
        add_vec(2'd3, 3, 16'hFFFF, 16'd1, 16'h8000, 16'd0, 16'd0, 32'hFFFF, 1'b0);
        add_vec(2'd2, 1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd1, 1'b0);
        foreach (vq[i]) begin
            for (int k = 0; k < 5; k++) stim[k] = vq[i].d[k];
            run_job($sformatf("vec%0d", i), vq[i].mode, int'(vq[i].len), -1, 0, 0,
                    vq[i].exp_acc, vq[i].exp_ovf);
        end

        // Randomized jobs with random stalls, checked against the model
        for (int j = 0; j < 25; j++) begin
            m = 2'($urandom);
            n = (j % 7 == 6) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 12));
            for (int k = 0; k < 256; k++) begin
                stim[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            end
            model(m, n, ea, eo);
            run_job($sformatf("rnd%0d m%0d n%0d", j, m, n), m, n, -1, 0, 1, ea, eo);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
